// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 mouse receive path: frame FSM states,
// frame/packet geometry, header bit positions and the parity check helper.
package ps2_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } frame_state_t;

  localparam int PS2_FRAME_BITS = 11;
  localparam int PS2_DATA_BITS  = PS2_FRAME_BITS - 3;
  localparam int PKT_BYTES      = 3;

  // Header (byte 0) bit positions
  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
  localparam int BTN_M = 2;
  localparam int SYNC  = 3;
  localparam int XS    = 4;
  localparam int YS    = 5;
  localparam int XO    = 6;
  localparam int YO    = 7;

  // True when data byte plus parity bit carry an odd number of ones
  function automatic logic odd_parity_ok(input logic [7:0] data_byte, input logic par_bit);
    return ^{data_byte, par_bit};
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Synchroniser and glitch filter for the PS/2 clock line. The filtered level
// only changes after FILT_LEN consecutive samples disagree with it; a one-cycle
// strobe marks each filtered 1->0 transition.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILT_LEN = 8
) (
  input  logic clock_100Mhz,
  input  logic reset,
  input  logic line_in,
  output logic fall_strobe
);

  localparam int CNT_W = $clog2(FILT_LEN + 1);

  logic [1:0]       sync_r;
  logic             filt_r;
  logic [CNT_W-1:0] cnt_r;
  logic             strobe_r;

  // Two-flop synchroniser for the asynchronous line
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      sync_r <= 2'b00;
    end else begin
      sync_r <= {sync_r[0], line_in};
    end
  end

  // Glitch filter: count disagreeing samples, flip level after FILT_LEN in a row
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      filt_r   <= 1'b0;
      cnt_r    <= '0;
      strobe_r <= 1'b0;
    end else begin
      strobe_r <= 1'b0;
      if (sync_r[1] != filt_r) begin
        if (cnt_r == CNT_W'(FILT_LEN - 1)) begin
          filt_r   <= sync_r[1];
          cnt_r    <= '0;
          strobe_r <= filt_r & ~sync_r[1];
        end else begin
          cnt_r <= cnt_r + CNT_W'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign fall_strobe = strobe_r;

endmodule

// File: rtl/ps2_mouse_packet_rx.sv
// PS/2 mouse receiver: filtered clock strobe drives an 11-bit frame FSM with
// parity/stop checking and a bit timeout; good bytes are assembled into
// 3-byte movement packets presented on registered outputs.
module ps2_mouse_packet_rx
  import ps2_pkg::*;
#(
  parameter int FILT_LEN    = 8,
  parameter int BIT_TIMEOUT = 10000,
  parameter int PKT_TIMEOUT = 200000
) (
  input  logic       clock_100Mhz,
  input  logic       reset,
  input  logic       Mouse_Clk,
  input  logic       Mouse_Data,
  output logic       packet_valid,
  output logic       btn_left,
  output logic       btn_right,
  output logic       btn_middle,
  output logic [8:0] x_delta,
  output logic [8:0] y_delta,
  output logic       x_ovf,
  output logic       y_ovf,
  output logic       frame_err
);

  localparam int         BT_W     = $clog2(BIT_TIMEOUT + 1);
  localparam int         PT_W     = $clog2(PKT_TIMEOUT + 1);
  localparam logic [2:0] LAST_BIT = 3'(PS2_DATA_BITS - 1);
  localparam logic [1:0] LAST_IDX = 2'(PKT_BYTES - 1);

  logic            strobe_s;
  logic            data_s;
  logic [2:0]      d_sync_r;
  frame_state_t    state_r, state_nxt_s;
  logic [2:0]      bit_cnt_r, bit_cnt_nxt_s;
  logic [7:0]      shift_r, shift_nxt_s;
  logic            parity_r, parity_nxt_s;
  logic            byte_ok_s, err_s, tmo_s;
  logic [BT_W-1:0] bit_tmr_r;
  logic [PT_W-1:0] pkt_tmr_r;
  logic [1:0]      idx_r;
  logic [7:0]      hdr_r, x_r;

  ps2_line_filter #(.FILT_LEN(FILT_LEN)) u_clk_filt (
    .clock_100Mhz (clock_100Mhz),
    .reset        (reset),
    .line_in      (Mouse_Clk),
    .fall_strobe  (strobe_s)
  );

  // Data line: 2-flop sync plus one stage to line up with the clock filter
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      d_sync_r <= 3'b000;
    end else begin
      d_sync_r <= {d_sync_r[1:0], Mouse_Data};
    end
  end

  assign data_s = d_sync_r[2];
  assign tmo_s  = (state_r != ST_IDLE) && (bit_tmr_r >= BT_W'(BIT_TIMEOUT));

  // Frame FSM and shift register state
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      state_r   <= ST_IDLE;
      bit_cnt_r <= 3'd0;
      shift_r   <= 8'h00;
      parity_r  <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      bit_cnt_r <= bit_cnt_nxt_s;
      shift_r   <= shift_nxt_s;
      parity_r  <= parity_nxt_s;
    end
  end

  // Frame FSM next state; a strobe takes priority over a coincident timeout
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    parity_nxt_s  = parity_r;
    byte_ok_s     = 1'b0;
    err_s         = 1'b0;
    if (strobe_s) begin
      case (state_r)
        ST_IDLE: begin
          if (!data_s) begin
            state_nxt_s   = ST_DATA;
            bit_cnt_nxt_s = 3'd0;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_DATA: begin
          shift_nxt_s = {data_s, shift_r[7:1]};
          if (bit_cnt_r == LAST_BIT) begin
            state_nxt_s = ST_PARITY;
          end else begin
            bit_cnt_nxt_s = bit_cnt_r + 3'd1;
          end
        end
        ST_PARITY: begin
          parity_nxt_s = data_s;
          state_nxt_s  = ST_STOP;
        end
        ST_STOP: begin
          if (odd_parity_ok(shift_r, parity_r) && data_s) begin
            byte_ok_s = 1'b1;
          end else begin
            err_s = 1'b1;
          end
          state_nxt_s = ST_IDLE;
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end else if (tmo_s) begin
      state_nxt_s = ST_IDLE;
      err_s       = 1'b1;
    end else begin
      state_nxt_s = state_r;
    end
  end

  // Bit timer: cycles since the last strobe while a frame is in progress
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      bit_tmr_r <= '0;
    end else if (strobe_s || (state_r == ST_IDLE)) begin
      bit_tmr_r <= '0;
    end else if (bit_tmr_r < BT_W'(BIT_TIMEOUT)) begin
      bit_tmr_r <= bit_tmr_r + BT_W'(1);
    end
  end

  // Packet timer: cycles since the last good byte while a packet is partial
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      pkt_tmr_r <= '0;
    end else if (byte_ok_s || (idx_r == 2'd0)) begin
      pkt_tmr_r <= '0;
    end else if (pkt_tmr_r < PT_W'(PKT_TIMEOUT)) begin
      pkt_tmr_r <= pkt_tmr_r + PT_W'(1);
    end
  end

  // Packet assembler and registered outputs
  always_ff @(posedge clock_100Mhz or posedge reset) begin
    if (reset) begin
      idx_r        <= 2'd0;
      hdr_r        <= 8'h00;
      x_r          <= 8'h00;
      packet_valid <= 1'b0;
      frame_err    <= 1'b0;
      btn_left     <= 1'b0;
      btn_right    <= 1'b0;
      btn_middle   <= 1'b0;
      x_delta      <= 9'h000;
      y_delta      <= 9'h000;
      x_ovf        <= 1'b0;
      y_ovf        <= 1'b0;
    end else begin
      packet_valid <= 1'b0;
      frame_err    <= err_s;
      if (err_s) begin
        idx_r <= 2'd0;
      end else if (byte_ok_s) begin
        if (idx_r == 2'd0) begin
          // Only a byte carrying the sync bit can start a packet
          if (shift_r[SYNC]) begin
            hdr_r <= shift_r;
            idx_r <= 2'd1;
          end
        end else if (idx_r == LAST_IDX) begin
          // Header is re-qualified by its sync bit before publishing
          if (hdr_r[SYNC]) begin
            btn_left     <= hdr_r[BTN_L];
            btn_right    <= hdr_r[BTN_R];
            btn_middle   <= hdr_r[BTN_M];
            x_delta      <= {hdr_r[XS], x_r};
            y_delta      <= {hdr_r[YS], shift_r};
            x_ovf        <= hdr_r[XO];
            y_ovf        <= hdr_r[YO];
            packet_valid <= 1'b1;
          end
          idx_r <= 2'd0;
        end else begin
          x_r   <= shift_r;
          idx_r <= idx_r + 2'd1;
        end
      end else if ((idx_r != 2'd0) && (pkt_tmr_r >= PT_W'(PKT_TIMEOUT))) begin
        idx_r <= 2'd0;
      end
    end
  end

endmodule
